seq_frame_tx: RTL

Serial frame transmitter that produces the bitstream a 10110 sequence detector consumes. It accepts a parallel payload word over a valid/ready handshake. It then shifts out one framed bit per clock: the 5-bit sync preamble, the payload MSB-first, and an odd-parity bit, followed by a programmable idle gap. It drives the 1-bit serial line into downstream detector/receiver logic and into test loopbacks.

---
 rtl/seq_frame_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seq_frame_tx.sv
// ---------------------------------------------------------------------------
// seq_frame_tx
//
// Serial frame transmitter. A payload word is taken over a valid/ready
// handshake and sent one bit per clock as:
//   PATTERN (PAT_W bits, MSB first) | payload (DATA_W bits, MSB first) |
//   odd parity bit
// followed by GAP idle cycles before the next word can be accepted.
//
// Handshake: a word transfers on the rising clk edge where
// in_valid && in_ready. in_data is sampled only at that edge; while
// in_ready is low, in_valid/in_data are ignored and the sender must hold
// them until accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   payload valid
//   in_data    payload word
//   in_ready   block can accept a payload this cycle (IDLE and out of reset)
//   s_out      serial data line (IDLE_BIT when not transmitting)
//   s_en       s_out carries a frame bit this cycle
//   sync_mark  high during the last preamble bit
//   frame_done one-cycle pulse during the parity bit
//   busy       frame or idle gap in progress
// ---------------------------------------------------------------------------
module seq_frame_tx #(
  parameter int                PAT_W    = 5,
  parameter logic [PAT_W-1:0]  PATTERN  = 5'b10110,
  parameter int                DATA_W   = 8,
  parameter int                GAP      = 2,
  parameter logic              IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              s_out,
  output logic              s_en,
  output logic              sync_mark,
  output logic              frame_done,
  output logic              busy
);

  // One down-counter serves every phase; it is always reloaded explicitly
  // on a phase change, so it must hold the largest phase length minus one.
  localparam int MAX_A   = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int MAX_LEN = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  // Bit-select sources are widened to 2**CNT_W so the counter indexes them
  // at its natural width.
  localparam int EXT_W   = 1 << CNT_W;
  localparam logic [EXT_W-1:0] PAT_EXT = EXT_W'(PATTERN);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t              state_q, state_n;
  cnt_t                cnt_q, cnt_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [EXT_W-1:0]    data_ext;

  logic s_out_n, s_en_n, sync_n, done_n, busy_n;

  // Combinational so a word can be accepted in the first cycle after reset
  // release; forced low while reset is asserted.
  assign in_ready = (state_q == ST_IDLE) && rst;

  // Next-state and counter logic.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_n  = in_data;
          state_n = ST_PRE;
          cnt_n   = cnt_t'(PAT_W - 1);
        end
      end
      ST_PRE: begin
        if (cnt_q == '0) begin
          state_n = ST_DATA;
          cnt_n   = cnt_t'(DATA_W - 1);
        end else begin
          cnt_n = cnt_q - cnt_t'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_n = ST_PAR;
        end else begin
          cnt_n = cnt_q - cnt_t'(1);
        end
      end
      ST_PAR: begin
        if (GAP > 0) begin
          state_n = ST_GAP;
          cnt_n   = cnt_t'(GAP - 1);
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output decode from the *next* state/counter/payload, so the registered
  // outputs line up with the state they describe: the first preamble bit is
  // on s_out in the cycle right after the accepting edge.
  always_comb begin
    s_out_n  = IDLE_BIT;
    s_en_n   = 1'b0;
    sync_n   = 1'b0;
    done_n   = 1'b0;
    busy_n   = 1'b0;
    data_ext = EXT_W'(data_n);
    case (state_n)
      ST_PRE: begin
        s_out_n = PAT_EXT[cnt_n];
        s_en_n  = 1'b1;
        sync_n  = (cnt_n == '0);
        busy_n  = 1'b1;
      end
      ST_DATA: begin
        s_out_n = data_ext[cnt_n];
        s_en_n  = 1'b1;
        busy_n  = 1'b1;
      end
      ST_PAR: begin
        // Odd parity: ones over payload + parity bit is odd.
        s_out_n = ~^data_n;
        s_en_n  = 1'b1;
        done_n  = 1'b1;
        busy_n  = 1'b1;
      end
      ST_GAP: begin
        busy_n = 1'b1;
      end
      default: begin
        s_out_n = IDLE_BIT;
      end
    endcase
  end

  // State, counter, payload and registered outputs. Reset aborts any frame
  // in progress and discards the latched payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      s_out      <= IDLE_BIT;
      s_en       <= 1'b0;
      sync_mark  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      data_q     <= data_n;
      s_out      <= s_out_n;
      s_en       <= s_en_n;
      sync_mark  <= sync_n;
      frame_done <= done_n;
      busy       <= busy_n;
    end
  end

endmodule
